// File: rtl/fixed_point_vec_mul.sv
// Element-wise signed fixed-point vector multiplier: one shared multiplier walks the
// captured operand vectors one element per cycle, saturating each product to WIDTH bits.
module fixed_point_vec_mul #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FRAC_BITS  = 3,
  parameter int unsigned NUM_INPUTS = 16
) (
  input  logic                                CLK,
  input  logic                                RSTN,
  input  logic [NUM_INPUTS-1:0][WIDTH-1:0]    VALUES_A_IN,
  input  logic [NUM_INPUTS-1:0][WIDTH-1:0]    VALUES_B_IN,
  input  logic                                VALID_IN,
  output logic                                READY_OUT,
  output logic [NUM_INPUTS-1:0][WIDTH-1:0]    VALUES_OUT,
  output logic                                VALID_OUT,
  output logic                                OVERFLOW_OUT
);

  localparam int unsigned IdxW  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned ProdW = 2 * WIDTH;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_INPUTS - 1);

  // Clamp limits sign-extended to the full product width for a signed compare.
  localparam logic signed [ProdW-1:0] MaxVal = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ProdW-1:0] MinVal = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMultiply, StDone} state_e;

  state_e                            state_q, state_d;
  logic [IdxW-1:0]                   idx_q, idx_d;
  logic [NUM_INPUTS-1:0][WIDTH-1:0]  a_q, b_q;
  logic                              load, step;

  logic signed [WIDTH-1:0]           op_a, op_b;
  logic signed [ProdW-1:0]           prod, shifted;
  logic                              sat_hi, sat_lo;
  logic [WIDTH-1:0]                  sat_val;

  assign READY_OUT = (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (VALID_IN) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = StMultiply;
        end
      end
      StMultiply: begin
        step = 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    op_a    = $signed(a_q[idx_q]);
    op_b    = $signed(b_q[idx_q]);
    prod    = op_a * op_b;
    // Arithmetic shift truncates toward -infinity; no rounding.
    shifted = prod >>> FRAC_BITS;
    sat_hi  = (shifted > MaxVal);
    sat_lo  = (shifted < MinVal);
    if (sat_hi) begin
      sat_val = MaxVal[WIDTH-1:0];
    end else if (sat_lo) begin
      sat_val = MinVal[WIDTH-1:0];
    end else begin
      sat_val = shifted[WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      VALUES_OUT   <= '0;
      VALID_OUT    <= 1'b0;
      OVERFLOW_OUT <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      VALID_OUT <= (state_q == StDone);
      if (load) begin
        a_q          <= VALUES_A_IN;
        b_q          <= VALUES_B_IN;
        OVERFLOW_OUT <= 1'b0;
      end
      if (step) begin
        VALUES_OUT[idx_q] <= sat_val;
        OVERFLOW_OUT      <= OVERFLOW_OUT | sat_hi | sat_lo;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_vec_mul.sv
// Directed and randomised checks of fixed_point_vec_mul with a 4-element and a
// 16-element instance (WIDTH=8, FRAC_BITS=3) sharing clock and reset.
module tb_fixed_point_vec_mul;

  logic clk;
  logic rstn;

  logic              valid4, ready4, valid_out4, ovf4;
  logic [3:0][7:0]   a4, b4, vout4;
  logic              valid16, ready16, valid_out16, ovf16;
  logic [15:0][7:0]  a16, b16, vout16;

  int errors = 0;
  int checks = 0;

  fixed_point_vec_mul #(.WIDTH(8), .FRAC_BITS(3), .NUM_INPUTS(4)) dut4 (
    .CLK          (clk),
    .RSTN         (rstn),
    .VALUES_A_IN  (a4),
    .VALUES_B_IN  (b4),
    .VALID_IN     (valid4),
    .READY_OUT    (ready4),
    .VALUES_OUT   (vout4),
    .VALID_OUT    (valid_out4),
    .OVERFLOW_OUT (ovf4)
  );

  fixed_point_vec_mul #(.WIDTH(8), .FRAC_BITS(3), .NUM_INPUTS(16)) dut16 (
    .CLK          (clk),
    .RSTN         (rstn),
    .VALUES_A_IN  (a16),
    .VALUES_B_IN  (b16),
    .VALID_IN     (valid16),
    .READY_OUT    (ready16),
    .VALUES_OUT   (vout16),
    .VALID_OUT    (valid_out16),
    .OVERFLOW_OUT (ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Listed element 0 first.
  function automatic logic [3:0][7:0] vec4(input logic [7:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  // Reference: exact integer product, floor-divide by 2^3, clamp to int8.
  function automatic logic [7:0] model_mul(input logic [7:0] a, input logic [7:0] b,
                                           output logic ovf);
    int p, q;
    p   = int'($signed(a)) * int'($signed(b));
    q   = p / 8;
    if (p < 0 && (p % 8) != 0) q = q - 1;
    ovf = 1'b0;
    if (q > 127) begin
      q   = 127;
      ovf = 1'b1;
    end else if (q < -128) begin
      q   = -128;
      ovf = 1'b1;
    end
    return q[7:0];
  endfunction

  // Issue one vector to dut4 and wait (bounded) for its VALID_OUT pulse.
  task automatic run4(input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                      output int lat, output int busy,
                      output logic [3:0][7:0] vals, output logic ovf);
    @(negedge clk);
    a4 = a; b4 = b; valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0; a4 = ~a; b4 = ~b;
    lat = 0; busy = 0;
    while (!valid_out4 && lat < 40) begin
      if (!ready4) busy++;
      @(negedge clk);
      lat++;
    end
    vals = vout4;
    ovf  = ovf4;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    checks++;
    if (ready4 !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", ready4);
    end
    checks++;
    if (valid_out4 !== 1'b0 || ovf4 !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got valid=%b ovf=%b expected 0/0", valid_out4, ovf4);
    end
    checks++;
    if (vout4 !== 32'h0 || vout16 !== 128'h0) begin
      errors++; $display("FAIL reset_values: got %h / %h expected all zero", vout4, vout16);
    end
  endtask

  task automatic test_basic();
    int lat, busy;
    logic [3:0][7:0] vals;
    logic ovf;
    run4(vec4(8'h0C, 8'hF4, 8'h08, 8'h00), vec4(8'h10, 8'h10, 8'h08, 8'h55), lat, busy, vals, ovf);
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL basic_latency: got %0d cycles expected 5", lat);
    end
    checks++;
    if (busy !== 5) begin
      errors++; $display("FAIL basic_ready_low: got %0d busy cycles expected 5", busy);
    end
    checks++;
    if (vals !== vec4(8'h18, 8'hE8, 8'h08, 8'h00)) begin
      errors++; $display("FAIL basic_values: got %h expected %h", vals,
                         vec4(8'h18, 8'hE8, 8'h08, 8'h00));
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL basic_overflow: got %b expected 0", ovf);
    end
    @(negedge clk);
    checks++;
    if (valid_out4 !== 1'b0) begin
      errors++; $display("FAIL basic_pulse_width: got %b expected 0 one cycle later", valid_out4);
    end
  endtask

  task automatic test_saturation();
    int lat, busy;
    logic [3:0][7:0] vals;
    logic ovf;
    run4(vec4(8'h40, 8'h80, 8'h80, 8'h7F), vec4(8'h20, 8'h80, 8'h7F, 8'h7F), lat, busy, vals, ovf);
    checks++;
    if (vals !== vec4(8'h7F, 8'h7F, 8'h80, 8'h7F)) begin
      errors++; $display("FAIL sat_values: got %h expected %h", vals,
                         vec4(8'h7F, 8'h7F, 8'h80, 8'h7F));
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL sat_overflow: got %b expected 1", ovf);
    end
    run4(vec4(8'h0C, 8'hF4, 8'h08, 8'h00), vec4(8'h10, 8'h10, 8'h08, 8'h55), lat, busy, vals, ovf);
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL sat_overflow_cleared: got %b expected 0", ovf);
    end
  endtask

  task automatic test_truncation();
    int lat, busy;
    logic [3:0][7:0] vals;
    logic ovf;
    run4(vec4(8'h01, 8'hFF, 8'h03, 8'hFD), vec4(8'h01, 8'h01, 8'h03, 8'h03), lat, busy, vals, ovf);
    checks++;
    if (vals !== vec4(8'h00, 8'hFF, 8'h01, 8'hFE)) begin
      errors++; $display("FAIL trunc_values: got %h expected %h", vals,
                         vec4(8'h00, 8'hFF, 8'h01, 8'hFE));
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL trunc_overflow: got %b expected 0", ovf);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    @(negedge clk);
    a4 = vec4(8'h0C, 8'hF4, 8'h08, 8'h00);
    b4 = vec4(8'h10, 8'h10, 8'h08, 8'h55);
    valid4 = 1'b1;
    @(negedge clk);
    // Second vector presented while busy; it must only be taken in the VALID_OUT cycle.
    a4 = vec4(8'h01, 8'hFF, 8'h03, 8'hFD);
    b4 = vec4(8'h01, 8'h01, 8'h03, 8'h03);
    cnt = 0;
    while (!valid_out4 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt !== 5) begin
      errors++; $display("FAIL b2b_first_latency: got %0d expected 5", cnt);
    end
    checks++;
    if (vout4 !== vec4(8'h18, 8'hE8, 8'h08, 8'h00)) begin
      errors++; $display("FAIL b2b_first_values: got %h expected %h", vout4,
                         vec4(8'h18, 8'hE8, 8'h08, 8'h00));
    end
    @(negedge clk);
    a4 = 32'h5A5A_5A5A; b4 = 32'hA5A5_A5A5;
    checks++;
    if (ready4 !== 1'b0) begin
      errors++; $display("FAIL b2b_second_accept: got ready=%b expected 0", ready4);
    end
    checks++;
    if (vout4 !== vec4(8'h18, 8'hE8, 8'h08, 8'h00)) begin
      errors++; $display("FAIL b2b_hold_after_accept: got %h expected %h", vout4,
                         vec4(8'h18, 8'hE8, 8'h08, 8'h00));
    end
    cnt = 1;
    while (!valid_out4 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    valid4 = 1'b0;
    checks++;
    if (cnt !== 6) begin
      errors++; $display("FAIL b2b_interval: got %0d cycles expected 6", cnt);
    end
    checks++;
    if (vout4 !== vec4(8'h00, 8'hFF, 8'h01, 8'hFE)) begin
      errors++; $display("FAIL b2b_second_values: got %h expected %h", vout4,
                         vec4(8'h00, 8'hFF, 8'h01, 8'hFE));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat, busy;
    logic [3:0][7:0] vals;
    logic ovf;
    bit seen;
    @(negedge clk);
    a4 = vec4(8'h40, 8'h80, 8'h80, 8'h7F);
    b4 = vec4(8'h20, 8'h80, 8'h7F, 8'h7F);
    valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    checks++;
    if (vout4 !== 32'h0 || ovf4 !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: got %h ovf=%b expected 0 ovf=0", vout4, ovf4);
    end
    checks++;
    if (ready4 !== 1'b1) begin
      errors++; $display("FAIL abort_ready: got %b expected 1", ready4);
    end
    seen = 1'b0;
    repeat (10) begin
      if (valid_out4) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_valid: got VALID_OUT=1 expected no pulse");
    end
    run4(vec4(8'h0C, 8'hF4, 8'h08, 8'h00), vec4(8'h10, 8'h10, 8'h08, 8'h55), lat, busy, vals, ovf);
    checks++;
    if (lat !== 5 || vals !== vec4(8'h18, 8'hE8, 8'h08, 8'h00)) begin
      errors++; $display("FAIL abort_recover: got lat=%0d vals=%h expected lat=5 vals=%h", lat, vals,
                         vec4(8'h18, 8'hE8, 8'h08, 8'h00));
    end
  endtask

  task automatic test_random16();
    logic [15:0][7:0] exp_v;
    logic             exp_ovf, e_ovf;
    logic [7:0]       extremes [4];
    int               cnt;
    extremes[0] = 8'h80; extremes[1] = 8'h7F; extremes[2] = 8'h00; extremes[3] = 8'hFF;
    for (int v = 0; v < 1000; v++) begin
      @(negedge clk);
      exp_ovf = 1'b0;
      for (int i = 0; i < 16; i++) begin
        a16[i] = ($urandom_range(0, 7) == 0) ? extremes[$urandom_range(0, 3)] : 8'($urandom);
        b16[i] = ($urandom_range(0, 7) == 0) ? extremes[$urandom_range(0, 3)] : 8'($urandom);
        exp_v[i] = model_mul(a16[i], b16[i], e_ovf);
        exp_ovf  = exp_ovf | e_ovf;
      end
      valid16 = 1'b1;
      @(negedge clk);
      valid16 = 1'b0;
      a16 = {4{32'($urandom)}};
      b16 = {4{32'($urandom)}};
      cnt = 0;
      while (!valid_out16 && cnt < 60) begin
        @(negedge clk);
        cnt++;
      end
      if (v == 0) begin
        checks++;
        if (cnt !== 17) begin
          errors++; $display("FAIL rand_latency: got %0d expected 17", cnt);
        end
      end
      checks++;
      if (vout16 !== exp_v) begin
        errors++; $display("FAIL rand_values[%0d]: got %h expected %h", v, vout16, exp_v);
      end
      checks++;
      if (ovf16 !== exp_ovf) begin
        errors++; $display("FAIL rand_overflow[%0d]: got %b expected %b", v, ovf16, exp_ovf);
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        checks++;
        if (vout16 !== exp_v || ovf16 !== exp_ovf) begin
          errors++; $display("FAIL rand_hold[%0d]: got %h/%b expected %h/%b", v, vout16, ovf16,
                             exp_v, exp_ovf);
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    valid4 = 1'b0; a4 = '0; b4 = '0;
    valid16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_truncation();
    test_back_to_back();
    test_reset_abort();
    test_random16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
